// File: rtl/lcd_rd_buffer_if.sv
// DDR burst-read channel between the LCD prefetch buffer (master) and the DDR controller (slave).
interface lcd_rd_buffer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 24
) ();
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_data_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ack,
    input  rd_data_valid,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ack,
    output rd_data_valid,
    output rd_data
  );
endinterface

// File: rtl/lcd_rd_buffer.sv
// Frame prefetch buffer: bursts one frame of packed RGB565 words from DDR into a show-ahead
// FIFO feeding the LCD timing stage; restarts from the frame base on every vsync fall.
module lcd_rd_buffer #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 24,
  parameter int unsigned       DEPTH       = 256,
  parameter int unsigned       BURST_LEN   = 32,
  parameter int unsigned       FRAME_WORDS = 65280,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                   lcd_clk,
  input  logic                   lcd_rst_n,
  input  logic                   ddr_init_done,
  input  logic                   lcd_framesync,
  input  logic                   ddr_rden,
  output logic [DATA_W-1:0]      ddr_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   underflow,
  output logic                   overflow,
  lcd_rd_buffer_if.master        rd
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned LvlW  = PtrW + 1;
  localparam int unsigned BeatW = $clog2(BURST_LEN + 1);
  localparam int unsigned WordW = $clog2(FRAME_WORDS + 1);

  typedef enum logic [2:0] {StIdle, StFlush, StReq, StData, StDone} state_e;

  state_e            state_q, state_d;
  logic              sync_q;
  logic [BeatW-1:0]  beats_q, beats_d;
  logic [WordW-1:0]  req_words_q, req_words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              halt_q, halt_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q;
  logic              underflow_q, overflow_q;

  logic fs, ack, flush, wr_en, push, pop, full, room;

  assign fs    = sync_q & ~lcd_framesync;
  assign ack   = req_q & rd.rd_ack;
  assign full  = (level_q == LvlW'(DEPTH));
  assign room  = (32'(level_q) + BURST_LEN) <= DEPTH;
  assign push  = wr_en & ~full;
  assign pop   = ddr_rden & (level_q != '0);

  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    req_words_d = req_words_q;
    addr_d      = addr_q;
    req_d       = req_q;
    halt_d      = halt_q;
    flush       = 1'b0;
    wr_en       = 1'b0;
    // Any returned beat retires one outstanding beat, whether stored or discarded.
    if (rd.rd_data_valid && beats_q != '0) beats_d = beats_q - BeatW'(1);
    // Losing DDR mid-frame parks the engine until the next frame start.
    if (state_q != StIdle && !ddr_init_done) halt_d = 1'b1;
    unique case (state_q)
      StIdle: if (ddr_init_done && fs) state_d = StFlush;
      StFlush: begin
        if (beats_q == '0) begin
          flush       = 1'b1;
          addr_d      = BASE_ADDR;
          req_words_d = '0;
          halt_d      = ~ddr_init_done;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (ack) begin
          req_d       = 1'b0;
          beats_d     = BeatW'(BURST_LEN);
          req_words_d = req_words_q + WordW'(BURST_LEN);
          state_d     = StData;
        end else if (!req_q) begin
          if (req_words_q == WordW'(FRAME_WORDS)) state_d = StDone;
          else if (ddr_init_done && !halt_q && room) req_d = 1'b1;
        end
      end
      StData: begin
        if (rd.rd_data_valid && beats_q != '0) begin
          wr_en = 1'b1;
          if (beats_q == BeatW'(1)) begin
            addr_d  = addr_q + ADDR_W'(BURST_LEN);
            state_d = StReq;
          end
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
    // Frame start aborts everything; an already-acked burst is drained in StFlush.
    if (fs && state_q != StIdle) begin
      state_d = StFlush;
      req_d   = 1'b0;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge lcd_clk or negedge lcd_rst_n) begin
    if (!lcd_rst_n) begin
      state_q     <= StIdle;
      sync_q      <= 1'b1;
      beats_q     <= '0;
      req_words_q <= '0;
      addr_q      <= BASE_ADDR;
      req_q       <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= lcd_framesync;
      beats_q     <= beats_d;
      req_words_q <= req_words_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      halt_q      <= halt_d;
    end
  end

  always_ff @(posedge lcd_clk or negedge lcd_rst_n) begin
    if (!lcd_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_q + LvlW'(push) - LvlW'(pop);
      if (ddr_rden && level_q == '0) underflow_q <= 1'b1;
      if (wr_en && full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge lcd_clk) begin
    if (push) mem[wr_ptr_q] <= rd.rd_data;
  end

  assign ddr_data   = (level_q != '0) ? mem[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign underflow  = underflow_q;
  assign overflow   = overflow_q;
  assign rd.rd_req  = req_q;
  assign rd.rd_addr = addr_q;

endmodule
